// File: rtl/axi_chan_compare.sv
// ---------------------------------------------------------------------------
// axi_chan_compare
//   Passive checker for two AXI ports that should carry the same traffic.
//   Every channel has its own in-order FIFO. The producing side pushes into it
//   and the consuming side pops from it and compares: A->B for aw/w/ar and
//   B->A for b/r. The module only watches the handshakes and never drives them.
//
// Configuration macro:
//   AXI_CHAN_COMPARE_ERR_CNT_EN  builds the 16-bit saturating mismatch counter.
//                                When it is undefined, err_cnt_o is 0.
//
// Ports (all status vectors are ordered {r, b, ar, w, aw}, bit 0 = aw):
//   clk_1                    sole clock, rising edge
//   rst_1_n                  asynchronous reset, active HIGH (legacy name)
//   a_<ch>_valid/ready/data  side-A observed handshake and payload
//   b_<ch>_valid/ready/data  side-B observed handshake and payload
//   mismatch_o [4:0]         one-cycle pulse, the cycle after a failing pop
//   err_o      [4:0]         sticky mismatch flag
//   ovf_o      [4:0]         sticky FIFO overflow (payload dropped)
//   unf_o      [4:0]         sticky pop-with-nothing-expected flag
//   err_cnt_o  [15:0]        saturating total mismatch count
// ---------------------------------------------------------------------------

// Single-channel scoreboard: FIFO of expected payloads plus compare and flags.
module axi_chan_compare_ch #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic             clk_1,
    input  logic             rst_1_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_push_data,
    input  logic             i_pop,
    input  logic [Width-1:0] i_pop_data,
    output logic             o_mismatch,
    output logic             o_err,
    output logic             o_ovf,
    output logic             o_unf
);
    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW:0]    r_wr_ptr;
    logic [PtrW:0]    r_rd_ptr;

    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_do_cmp;
    logic             w_write;
    logic             w_adv_rd;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_mis;
    logic [Width-1:0] w_expected;

    // The extra MSB on each pointer is the wrap bit that tells full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]) &&
                     (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]);

    // Push and pop together on an empty FIFO: compare the pushed beat directly.
    assign w_bypass   = i_push && i_pop && w_empty;
    assign w_do_cmp   = i_pop && (i_push || !w_empty);
    assign w_expected = w_bypass ? i_push_data : r_mem[r_rd_ptr[PtrW-1:0]];

    // A pop in the same cycle frees the head slot, so a push on full is accepted.
    assign w_write   = i_push && !w_bypass && (!w_full || i_pop);
    assign w_adv_rd  = i_pop && !w_empty;
    assign w_ovf_evt = i_push && w_full && !i_pop;
    assign w_unf_evt = i_pop && !i_push && w_empty;

    // Case inequality, so an X or Z bit on either side counts as a mismatch.
    assign w_mis = w_do_cmp && (w_expected !== i_pop_data);

    // NOTE: payload storage has no reset; the pointers alone define validity,
    // and leaving it reset-free lets the array map onto plain RAM.
    always_ff @(posedge clk_1) begin
        if (w_write) begin
            r_mem[r_wr_ptr[PtrW-1:0]] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            o_mismatch <= 1'b0;
            o_err      <= 1'b0;
            o_ovf      <= 1'b0;
            o_unf      <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            o_mismatch <= w_mis;
            o_err      <= o_err | w_mis;
            o_ovf      <= o_ovf | w_ovf_evt;
            o_unf      <= o_unf | w_unf_evt;
        end
    end
endmodule

module axi_chan_compare #(
    parameter int AwWidth = 100,
    parameter int WWidth  = 577,
    parameter int BWidth  = 11,
    parameter int ArWidth = 100,
    parameter int RWidth  = 524,
    parameter int Depth   = 8
) (
    input  logic               clk_1,
    input  logic               rst_1_n,
    input  logic               a_aw_valid,
    input  logic               a_aw_ready,
    input  logic [AwWidth-1:0] a_aw_data,
    input  logic               a_w_valid,
    input  logic               a_w_ready,
    input  logic [WWidth-1:0]  a_w_data,
    input  logic               a_ar_valid,
    input  logic               a_ar_ready,
    input  logic [ArWidth-1:0] a_ar_data,
    input  logic               a_b_valid,
    input  logic               a_b_ready,
    input  logic [BWidth-1:0]  a_b_data,
    input  logic               a_r_valid,
    input  logic               a_r_ready,
    input  logic [RWidth-1:0]  a_r_data,
    input  logic               b_aw_valid,
    input  logic               b_aw_ready,
    input  logic [AwWidth-1:0] b_aw_data,
    input  logic               b_w_valid,
    input  logic               b_w_ready,
    input  logic [WWidth-1:0]  b_w_data,
    input  logic               b_ar_valid,
    input  logic               b_ar_ready,
    input  logic [ArWidth-1:0] b_ar_data,
    input  logic               b_b_valid,
    input  logic               b_b_ready,
    input  logic [BWidth-1:0]  b_b_data,
    input  logic               b_r_valid,
    input  logic               b_r_ready,
    input  logic [RWidth-1:0]  b_r_data,
    output logic [4:0]         mismatch_o,
    output logic [4:0]         err_o,
    output logic [4:0]         ovf_o,
    output logic [4:0]         unf_o,
    output logic [15:0]        err_cnt_o
);
    // Request channels flow A->B and response channels flow B->A.
    axi_chan_compare_ch #(.Width(AwWidth), .Depth(Depth)) u_aw (
        .clk_1(clk_1), .rst_1_n(rst_1_n),
        .i_push(a_aw_valid & a_aw_ready), .i_push_data(a_aw_data),
        .i_pop(b_aw_valid & b_aw_ready),  .i_pop_data(b_aw_data),
        .o_mismatch(mismatch_o[0]), .o_err(err_o[0]), .o_ovf(ovf_o[0]), .o_unf(unf_o[0])
    );

    axi_chan_compare_ch #(.Width(WWidth), .Depth(Depth)) u_w (
        .clk_1(clk_1), .rst_1_n(rst_1_n),
        .i_push(a_w_valid & a_w_ready), .i_push_data(a_w_data),
        .i_pop(b_w_valid & b_w_ready),  .i_pop_data(b_w_data),
        .o_mismatch(mismatch_o[1]), .o_err(err_o[1]), .o_ovf(ovf_o[1]), .o_unf(unf_o[1])
    );

    axi_chan_compare_ch #(.Width(ArWidth), .Depth(Depth)) u_ar (
        .clk_1(clk_1), .rst_1_n(rst_1_n),
        .i_push(a_ar_valid & a_ar_ready), .i_push_data(a_ar_data),
        .i_pop(b_ar_valid & b_ar_ready),  .i_pop_data(b_ar_data),
        .o_mismatch(mismatch_o[2]), .o_err(err_o[2]), .o_ovf(ovf_o[2]), .o_unf(unf_o[2])
    );

    axi_chan_compare_ch #(.Width(BWidth), .Depth(Depth)) u_b (
        .clk_1(clk_1), .rst_1_n(rst_1_n),
        .i_push(b_b_valid & b_b_ready), .i_push_data(b_b_data),
        .i_pop(a_b_valid & a_b_ready),  .i_pop_data(a_b_data),
        .o_mismatch(mismatch_o[3]), .o_err(err_o[3]), .o_ovf(ovf_o[3]), .o_unf(unf_o[3])
    );

    axi_chan_compare_ch #(.Width(RWidth), .Depth(Depth)) u_r (
        .clk_1(clk_1), .rst_1_n(rst_1_n),
        .i_push(b_r_valid & b_r_ready), .i_push_data(b_r_data),
        .i_pop(a_r_valid & a_r_ready),  .i_pop_data(a_r_data),
        .o_mismatch(mismatch_o[4]), .o_err(err_o[4]), .o_ovf(ovf_o[4]), .o_unf(unf_o[4])
    );

`ifdef AXI_CHAN_COMPARE_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [2:0]  w_inc;
    logic [16:0] w_sum;

    // Accumulates the registered pulses, so the count lags mismatch_o by a cycle.
    assign w_inc = {2'b00, mismatch_o[0]} + {2'b00, mismatch_o[1]} +
                   {2'b00, mismatch_o[2]} + {2'b00, mismatch_o[3]} +
                   {2'b00, mismatch_o[4]};
    assign w_sum = {1'b0, r_err_cnt} + {14'b0, w_inc};

    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = 16'h0;
`endif
endmodule

// File: tb/tb_axi_chan_compare.sv
// ---------------------------------------------------------------------------
// tb_axi_chan_compare
//   Directed bench for axi_chan_compare at its default widths. Inputs change
//   1 time unit after a rising edge and outputs are read at the same point.
//   Expected err_cnt_o follows AXI_CHAN_COMPARE_ERR_CNT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_axi_chan_compare;
    localparam int AwW = 100;
    localparam int WW  = 577;
    localparam int BW  = 11;
    localparam int ArW = 100;
    localparam int RW  = 524;
`ifdef AXI_CHAN_COMPARE_ERR_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk_1   = 1'b0;
    logic rst_1_n = 1'b1;

    logic           a_aw_valid, a_aw_ready, b_aw_valid, b_aw_ready;
    logic [AwW-1:0] a_aw_data, b_aw_data;
    logic           a_w_valid, a_w_ready, b_w_valid, b_w_ready;
    logic [WW-1:0]  a_w_data, b_w_data;
    logic           a_ar_valid, a_ar_ready, b_ar_valid, b_ar_ready;
    logic [ArW-1:0] a_ar_data, b_ar_data;
    logic           a_b_valid, a_b_ready, b_b_valid, b_b_ready;
    logic [BW-1:0]  a_b_data, b_b_data;
    logic           a_r_valid, a_r_ready, b_r_valid, b_r_ready;
    logic [RW-1:0]  a_r_data, b_r_data;

    logic [4:0]  mismatch_o, err_o, ovf_o, unf_o;
    logic [15:0] err_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    axi_chan_compare dut (
        .clk_1(clk_1), .rst_1_n(rst_1_n),
        .a_aw_valid(a_aw_valid), .a_aw_ready(a_aw_ready), .a_aw_data(a_aw_data),
        .a_w_valid(a_w_valid),   .a_w_ready(a_w_ready),   .a_w_data(a_w_data),
        .a_ar_valid(a_ar_valid), .a_ar_ready(a_ar_ready), .a_ar_data(a_ar_data),
        .a_b_valid(a_b_valid),   .a_b_ready(a_b_ready),   .a_b_data(a_b_data),
        .a_r_valid(a_r_valid),   .a_r_ready(a_r_ready),   .a_r_data(a_r_data),
        .b_aw_valid(b_aw_valid), .b_aw_ready(b_aw_ready), .b_aw_data(b_aw_data),
        .b_w_valid(b_w_valid),   .b_w_ready(b_w_ready),   .b_w_data(b_w_data),
        .b_ar_valid(b_ar_valid), .b_ar_ready(b_ar_ready), .b_ar_data(b_ar_data),
        .b_b_valid(b_b_valid),   .b_b_ready(b_b_ready),   .b_b_data(b_b_data),
        .b_r_valid(b_r_valid),   .b_r_ready(b_r_ready),   .b_r_data(b_r_data),
        .mismatch_o(mismatch_o), .err_o(err_o), .ovf_o(ovf_o), .unf_o(unf_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [4:0] mis, input logic [4:0] err,
                               input logic [4:0] ovf, input logic [4:0] unf);
        check({tag, ".mismatch"}, 16'(mismatch_o), 16'(mis));
        check({tag, ".err"},      16'(err_o),      16'(err));
        check({tag, ".ovf"},      16'(ovf_o),      16'(ovf));
        check({tag, ".unf"},      16'(unf_o),      16'(unf));
    endtask

    task automatic idle();
        a_aw_valid = 0; a_aw_ready = 0; b_aw_valid = 0; b_aw_ready = 0;
        a_w_valid  = 0; a_w_ready  = 0; b_w_valid  = 0; b_w_ready  = 0;
        a_ar_valid = 0; a_ar_ready = 0; b_ar_valid = 0; b_ar_ready = 0;
        a_b_valid  = 0; a_b_ready  = 0; b_b_valid  = 0; b_b_ready  = 0;
        a_r_valid  = 0; a_r_ready  = 0; b_r_valid  = 0; b_r_ready  = 0;
    endtask

    // One clock: the edge samples what was driven, then handshakes drop.
    task automatic tick();
        @(posedge clk_1);
        #1;
        idle();
    endtask

    logic [4:0] mis_seen;

    initial begin
        idle();
        a_aw_data = '0; b_aw_data = '0; a_w_data = '0; b_w_data = '0;
        a_ar_data = '0; b_ar_data = '0; a_b_data = '0; b_b_data = '0;
        a_r_data  = '0; b_r_data  = '0;

        // Reset held: everything cleared.
        repeat (2) @(posedge clk_1);
        #1;
        check_flags("reset", 5'b0, 5'b0, 5'b0, 5'b0);
        check("reset.cnt", err_cnt_o, 16'h0);
        @(negedge clk_1);
        rst_1_n = 1'b0;
        tick();

        // AW: matching beat, one cycle apart.
        a_aw_valid = 1; a_aw_ready = 1; a_aw_data = AwW'(16'h1234);
        tick();
        b_aw_valid = 1; b_aw_ready = 1; b_aw_data = AwW'(16'h1234);
        tick();
        check_flags("aw_match", 5'b0, 5'b0, 5'b0, 5'b0);

        // W: 0xA5 expected, 0xA4 observed.
        a_w_valid = 1; a_w_ready = 1; a_w_data = WW'(8'hA5);
        tick();
        b_w_valid = 1; b_w_ready = 1; b_w_data = WW'(8'hA4);
        tick();
        check_flags("w_mis", 5'b00010, 5'b00010, 5'b0, 5'b0);
        tick();
        check("w_pulse_end", 16'(mismatch_o), 16'h0);
        tick();
        check("w_cnt", err_cnt_o, CntEn ? 16'd1 : 16'd0);

        // R: fill to Depth, a 9th push overflows and is dropped.
        for (int i = 0; i < 8; i++) begin
            b_r_valid = 1; b_r_ready = 1; b_r_data = RW'(16'hD0 + 16'(i));
            tick();
        end
        check("r_full.ovf", 16'(ovf_o), 16'h0);
        b_r_valid = 1; b_r_ready = 1; b_r_data = RW'(16'hD8);
        tick();
        check("r_ovf", 16'(ovf_o), 16'b10000);
        mis_seen = '0;
        for (int i = 0; i < 8; i++) begin
            a_r_valid = 1; a_r_ready = 1; a_r_data = RW'(16'hD0 + 16'(i));
            tick();
            mis_seen |= mismatch_o;
        end
        tick();
        mis_seen |= mismatch_o;
        check("r_drain.mis", 16'(mis_seen), 16'h0);
        check("r_drain.err", 16'(err_o), 16'b00010);
        // Dropped beat never entered: one more pop finds the FIFO empty.
        a_r_valid = 1; a_r_ready = 1; a_r_data = RW'(16'hD8);
        tick();
        check_flags("r_unf", 5'b0, 5'b00010, 5'b10000, 5'b10000);

        // W: push+pop on a full FIFO is accepted and keeps it full.
        for (int i = 0; i < 8; i++) begin
            a_w_valid = 1; a_w_ready = 1; a_w_data = WW'(16'hF0 + 16'(i));
            tick();
        end
        a_w_valid = 1; a_w_ready = 1; a_w_data = WW'(16'hF8);
        b_w_valid = 1; b_w_ready = 1; b_w_data = WW'(16'hF0);
        tick();
        check("w_full_pp.mis", 16'(mismatch_o), 16'h0);
        check("w_full_pp.ovf", 16'(ovf_o), 16'b10000);
        a_w_valid = 1; a_w_ready = 1; a_w_data = WW'(16'hF9);
        tick();
        check("w_still_full.ovf", 16'(ovf_o), 16'b10010);
        mis_seen = '0;
        for (int i = 1; i < 9; i++) begin
            b_w_valid = 1; b_w_ready = 1; b_w_data = WW'(16'hF0 + 16'(i));
            tick();
            mis_seen |= mismatch_o;
        end
        tick();
        mis_seen |= mismatch_o;
        check("w_drain.mis", 16'(mis_seen), 16'h0);
        check("w_drain.unf", 16'(unf_o), 16'b10000);

        // B: side-A pop with nothing expected.
        a_b_valid = 1; a_b_ready = 1; a_b_data = BW'(3);
        tick();
        check_flags("b_unf", 5'b0, 5'b00010, 5'b10010, 5'b11000);

        // AR: bypass compare on empty, then a lone pop underflows.
        a_ar_valid = 1; a_ar_ready = 1; a_ar_data = ArW'(8'h55);
        b_ar_valid = 1; b_ar_ready = 1; b_ar_data = ArW'(8'h55);
        tick();
        check_flags("ar_bypass", 5'b0, 5'b00010, 5'b10010, 5'b11000);
        b_ar_valid = 1; b_ar_ready = 1; b_ar_data = ArW'(8'h55);
        tick();
        check_flags("ar_unf", 5'b0, 5'b00010, 5'b10010, 5'b11100);
        a_ar_valid = 1; a_ar_ready = 1; a_ar_data = ArW'(8'h55);
        b_ar_valid = 1; b_ar_ready = 1; b_ar_data = ArW'(8'h56);
        tick();
        check_flags("ar_bypass_mis", 5'b00100, 5'b00110, 5'b10010, 5'b11100);
        tick();
        tick();
        check("ar_cnt", err_cnt_o, CntEn ? 16'd2 : 16'd0);

        // Reset mid-operation with three AW beats queued.
        for (int i = 0; i < 3; i++) begin
            a_aw_valid = 1; a_aw_ready = 1; a_aw_data = AwW'(16'h100 + 16'(i));
            tick();
        end
        #2;
        rst_1_n = 1'b1;
        #1;
        check_flags("async_rst", 5'b0, 5'b0, 5'b0, 5'b0);
        check("async_rst.cnt", err_cnt_o, 16'h0);
        @(negedge clk_1);
        rst_1_n = 1'b0;
        b_aw_valid = 1; b_aw_ready = 1; b_aw_data = AwW'(16'h100);
        tick();
        check_flags("post_rst_unf", 5'b0, 5'b0, 5'b0, 5'b00001);

        // AW: payloads differing only in the top bit.
        a_aw_valid = 1; a_aw_ready = 1; a_aw_data = '0; a_aw_data[AwW-1] = 1'b1;
        tick();
        b_aw_valid = 1; b_aw_ready = 1; b_aw_data = '0;
        tick();
        check_flags("aw_msb", 5'b00001, 5'b00001, 5'b0, 5'b00001);
        tick();
        tick();
        check("aw_msb.cnt", err_cnt_o, CntEn ? 16'd1 : 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_chan_compare.md
AXI_CHAN_COMPARE -- requirements
Module: axi_chan_compare

Interface
REQ-001 SHALL have parameter AwWidth, default 100, meaning AW payload bit width.
REQ-002 SHALL have parameter WWidth, default 577, meaning W payload bit width.
REQ-003 SHALL have parameters BWidth (default 11), ArWidth (default 100) and RWidth (default 524), meaning B, AR and R payload widths.
REQ-004 SHALL have parameter Depth, default 8, meaning per-channel FIFO entries (power of two, at least 2).
REQ-005 clk_1  in  1  sole clock; both sides are sampled on its rising edge.
REQ-006 rst_1_n  in  1  reset, asynchronous, active-high.
REQ-007 a_<ch>_valid, a_<ch>_ready  in  1 each  side-A handshake, for ch in aw, w, ar, b, r.
REQ-008 a_<ch>_data  in  <Ch>Width  side-A payload, for each ch.
REQ-009 b_<ch>_valid, b_<ch>_ready  in  1 each  side-B handshake, for each ch.
REQ-010 b_<ch>_data  in  <Ch>Width  side-B payload, for each ch.
REQ-011 mismatch_o  out  5  one-cycle pulse per channel; bit order {r, b, ar, w, aw} (bit 0 = aw).
REQ-012 err_o  out  5  sticky mismatch flag per channel, same bit order.
REQ-013 ovf_o  out  5  sticky FIFO-overflow flag per channel.
REQ-014 unf_o  out  5  sticky "unexpected beat" flag per channel.
REQ-015 err_cnt_o  out  16  total mismatch count.

Function
REQ-016 A handshake SHALL be valid & ready sampled at the rising edge of clk_1.
REQ-017 For aw, w and ar, a side-A handshake SHALL push the payload and a side-B handshake SHALL pop and compare.
REQ-018 For b and r, a side-B handshake SHALL push the payload and a side-A handshake SHALL pop and compare.
REQ-019 Each channel SHALL have an independent in-order FIFO of Depth entries.
REQ-020 The compare SHALL check the full payload bitwise, with X treated as a mismatch.
REQ-021 On a mismatch, the channel bit of mismatch_o SHALL pulse high in the cycle after the pop handshake.
REQ-022 On a mismatch, the matching bit of err_o SHALL set and stay set until reset.
REQ-023 Simultaneous push and pop on an empty FIFO SHALL compare the pushed payload directly (bypass) and leave the FIFO empty.
REQ-024 Simultaneous push and pop on a non-empty FIFO SHALL compare against the head entry and keep the occupancy unchanged.
REQ-025 A pop on an empty FIFO without a simultaneous push SHALL set unf_o for that channel; no compare occurs.
REQ-026 A push on a full FIFO without a simultaneous pop SHALL set ovf_o for that channel and drop the payload.
REQ-027 A push on a full FIFO with a simultaneous pop SHALL be accepted.
REQ-028 Read and write pointers SHALL wrap modulo Depth, using an extra wrap bit to distinguish full from empty.
REQ-029 err_cnt_o SHALL add the number of mismatch_o bits set each cycle and saturate at 16'hFFFF.
REQ-030 The module SHALL be purely observational: no outputs feed back into the handshakes.

Reset
REQ-031 While rst_1_n is high, all FIFOs SHALL empty and mismatch_o, err_o, ovf_o, unf_o and err_cnt_o SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight entries immediately (asynchronously).
REQ-033 After release, monitoring SHALL start at the first clk_1 edge.

Configuration
REQ-034 When AXI_CHAN_COMPARE_ERR_CNT_EN is defined, the saturating 16-bit counter SHALL be built and drive err_cnt_o.
REQ-035 When AXI_CHAN_COMPARE_ERR_CNT_EN is undefined, no counter logic SHALL be built and err_cnt_o SHALL be tied to 16'h0.
REQ-036 All other behaviour SHALL be identical in both configurations.

Verification
REQ-037 AW: push 0x1234 on A, then B handshake with 0x1234 one cycle later -> mismatch_o=0, err_o=0.
REQ-038 W: push 0xA5 on A, then B handshake with 0xA4 -> mismatch_o[1] pulses one cycle, err_o[1]=1, err_cnt_o=1 (counter built).
REQ-039 R: push D0..D7 on B, then pop all 8 on A in order -> no errors; a 9th push before any pop -> ovf_o[4]=1.
REQ-040 B-channel: side-A handshake while empty and no side-B push -> unf_o[3]=1, mismatch_o=0.
REQ-041 AR: simultaneous push and pop of 0x55 on an empty FIFO -> bypass compare passes; a following pop -> unf_o[2]=1.
REQ-042 Reset: raise rst_1_n with 3 AW entries queued -> all outputs 0; afterwards a B-side AW pop -> unf_o[0]=1.
